// File: rtl/branch_outcome_predictor.sv
// Branch resolve and predict unit: picks the actual outcome from the comparator flags,
// trains a direct-mapped table of 2-bit counters, and raises a registered redirect on mispredict.
module branch_outcome_predictor #(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic [2:0]  funct3,
    input  logic        beq,
    input  logic        bne,
    input  logic        blt,
    input  logic        bge,
    input  logic        bltu,
    input  logic        bgeu,
    input  logic        pred_in,
    input  logic [31:0] target_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        illegal_br,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [1:0] CNT_RESET = 2'b01;

    // resolve_valid is a single-cycle qualifier with no back-pressure: every resolve input is
    // sampled at the rising edge only when resolve_valid=1 and is don't-care otherwise.

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic             r_illegal_br;
    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_resolve_idx;
    logic             w_taken;
    logic             w_legal;
    logic             w_mispredict;
    logic [1:0]       w_cnt_cur;
    logic [1:0]       w_cnt_next;
    logic             w_unused;

    assign w_fetch_idx   = fetch_pc[IDX_W+1:2];
    assign w_resolve_idx = resolve_pc[IDX_W+1:2];

    // Ignored PC bits are collected so unused-signal lint stays quiet.
    assign w_unused = &{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                        resolve_pc[1:0]};

    assign pred_taken = r_bht[w_fetch_idx][1];

    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (funct3)
            3'b000:  w_taken = beq;
            3'b001:  w_taken = bne;
            3'b100:  w_taken = blt;
            3'b101:  w_taken = bge;
            3'b110:  w_taken = bltu;
            3'b111:  w_taken = bgeu;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_mispredict = w_taken ^ pred_in;
    assign w_cnt_cur    = r_bht[w_resolve_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_taken) begin
            if (w_cnt_cur != 2'b11) begin
                w_cnt_next = w_cnt_cur + 2'b01;
            end
        end else begin
            if (w_cnt_cur != 2'b00) begin
                w_cnt_next = w_cnt_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= CNT_RESET;
            end
        end else if (resolve_valid && w_legal) begin
            r_bht[w_resolve_idx] <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect         <= 1'b0;
            r_redirect_pc      <= 32'h0;
            r_illegal_br       <= 1'b0;
            r_branch_count     <= 32'h0;
            r_mispredict_count <= 32'h0;
        end else if (resolve_valid && w_legal) begin
            r_redirect   <= w_mispredict;
            r_illegal_br <= 1'b0;
            if (r_branch_count != 32'hFFFF_FFFF) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? target_pc : (resolve_pc + 32'd4);
                if (r_mispredict_count != 32'hFFFF_FFFF) begin
                    r_mispredict_count <= r_mispredict_count + 32'd1;
                end
            end
        end else if (resolve_valid) begin
            r_redirect   <= 1'b0;
            r_illegal_br <= 1'b1;
        end else begin
            r_redirect   <= 1'b0;
            r_illegal_br <= 1'b0;
        end
    end

    assign redirect         = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign illegal_br       = r_illegal_br;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Directed bench for branch_outcome_predictor: resolve scenarios with hand-computed expectations.
module tb_branch_outcome_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        pred_taken;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = 32'h0;
    logic [2:0]  funct3 = 3'b000;
    logic        beq = 1'b0, bne = 1'b0, blt = 1'b0, bge = 1'b0, bltu = 1'b0, bgeu = 1'b0;
    logic        pred_in = 1'b0;
    logic [31:0] target_pc = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal_br;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int passed = 0;
    int total  = 0;

    branch_outcome_predictor #(.BHT_ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .funct3(funct3),
        .beq(beq), .bne(bne), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
        .pred_in(pred_in), .target_pc(target_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    // flags packed as {beq, bne, blt, bge, bltu, bgeu}
    task automatic drive_resolve(input logic [31:0] pc, input logic [2:0] f3,
                                 input logic [5:0] flags, input logic pin,
                                 input logic [31:0] tgt);
        resolve_valid = 1'b1;
        resolve_pc    = pc;
        funct3        = f3;
        {beq, bne, blt, bge, bltu, bgeu} = flags;
        pred_in       = pin;
        target_pc     = tgt;
    endtask

    task automatic drive_idle();
        resolve_valid = 1'b0;
        {beq, bne, blt, bge, bltu, bgeu} = 6'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (redirect !== 1'b0) $display("FAIL rst_redirect: got %b want 0", redirect); else passed++;
        total++; if (branch_count !== 32'h0) $display("FAIL rst_branch_count: got %h want 0", branch_count); else passed++;
        total++; if (mispredict_count !== 32'h0) $display("FAIL rst_mispredict_count: got %h want 0", mispredict_count); else passed++;
        total++; if (illegal_br !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal_br); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            total++;
            if (pred_taken !== 1'b0) $display("FAIL rst_pred idx %0d: got %b want 0", i, pred_taken);
            else passed++;
        end
    endtask

    task automatic test_first_mispredict();
        drive_resolve(32'h100, 3'b000, 6'b100000, 1'b0, 32'h200);
        step();
        drive_idle();
        total++; if (redirect !== 1'b1) $display("FAIL mp1_redirect: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'h200) $display("FAIL mp1_redirect_pc: got %h want 00000200", redirect_pc); else passed++;
        total++; if (branch_count !== 32'd1) $display("FAIL mp1_branch_count: got %0d want 1", branch_count); else passed++;
        total++; if (mispredict_count !== 32'd1) $display("FAIL mp1_mispredict_count: got %0d want 1", mispredict_count); else passed++;
        fetch_pc = 32'h100;
        #1;
        total++; if (pred_taken !== 1'b1) $display("FAIL mp1_pred: got %b want 1", pred_taken); else passed++;
        step();
        total++; if (redirect !== 1'b0) $display("FAIL mp1_one_cycle: got %b want 0", redirect); else passed++;
        total++; if (redirect_pc !== 32'h200) $display("FAIL mp1_pc_hold: got %h want 00000200", redirect_pc); else passed++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            drive_resolve(32'h100, 3'b000, 6'b100000, 1'b1, 32'h200);
            step();
            total++;
            if (redirect !== 1'b0) $display("FAIL sat_no_redirect %0d: got %b want 0", k, redirect);
            else passed++;
        end
        drive_resolve(32'h100, 3'b000, 6'b000000, 1'b1, 32'h200);
        step();
        drive_idle();
        total++; if (redirect !== 1'b1) $display("FAIL sat_nt_redirect: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'h104) $display("FAIL sat_nt_pc: got %h want 00000104", redirect_pc); else passed++;
        fetch_pc = 32'h100;
        #1;
        total++; if (pred_taken !== 1'b1) $display("FAIL sat_pred: got %b want 1", pred_taken); else passed++;
        total++; if (branch_count !== 32'd5) $display("FAIL sat_branch_count: got %0d want 5", branch_count); else passed++;
        total++; if (mispredict_count !== 32'd2) $display("FAIL sat_mispredict_count: got %0d want 2", mispredict_count); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        drive_resolve(32'h8, 3'b000, 6'b100000, 1'b0, 32'h300);
        step();
        total++; if (redirect !== 1'b1) $display("FAIL b2b_first: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'h300) $display("FAIL b2b_first_pc: got %h want 00000300", redirect_pc); else passed++;
        drive_resolve(32'h8, 3'b000, 6'b000000, 1'b1, 32'h300);
        step();
        drive_idle();
        total++; if (redirect !== 1'b1) $display("FAIL b2b_second: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'hC) $display("FAIL b2b_second_pc: got %h want 0000000c", redirect_pc); else passed++;
        fetch_pc = 32'h8;
        #1;
        total++; if (pred_taken !== 1'b0) $display("FAIL b2b_pred: got %b want 0", pred_taken); else passed++;
        step();
        total++; if (redirect !== 1'b0) $display("FAIL b2b_drop: got %b want 0", redirect); else passed++;
        total++; if (redirect_pc !== 32'hC) $display("FAIL b2b_pc_hold: got %h want 0000000c", redirect_pc); else passed++;
    endtask

    task automatic test_bltu_wrap();
        drive_resolve(32'hFFFF_FFFC, 3'b110, 6'b000010, 1'b0, 32'h1234);
        step();
        total++; if (redirect !== 1'b1) $display("FAIL bltu_redirect: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'h1234) $display("FAIL bltu_pc: got %h want 00001234", redirect_pc); else passed++;
        drive_resolve(32'hFFFF_FFFC, 3'b110, 6'b001000, 1'b1, 32'h1234);
        step();
        drive_idle();
        total++; if (redirect !== 1'b1) $display("FAIL wrap_redirect: got %b want 1", redirect); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL wrap_pc: got %h want 00000000", redirect_pc); else passed++;
        total++; if (branch_count !== 32'd9) $display("FAIL wrap_branch_count: got %0d want 9", branch_count); else passed++;
        total++; if (mispredict_count !== 32'd6) $display("FAIL wrap_mispredict_count: got %0d want 6", mispredict_count); else passed++;
        step();
    endtask

    task automatic test_funct3_select();
        logic [2:0] f3_tab [4];
        logic [5:0] flag_tab [4];
        f3_tab   = '{3'b001, 3'b100, 3'b101, 3'b111};
        flag_tab = '{6'b010000, 6'b001000, 6'b000100, 6'b000001};
        for (int k = 0; k < 4; k++) begin
            drive_resolve(32'h10, f3_tab[k], flag_tab[k], 1'b0, 32'h400 + 32'(k));
            step();
            total++;
            if (redirect !== 1'b1 || redirect_pc !== 32'h400 + 32'(k))
                $display("FAIL sel_taken f3=%b: got %b/%h want 1/%h", f3_tab[k], redirect, redirect_pc, 32'h400 + 32'(k));
            else passed++;
            drive_resolve(32'h10, f3_tab[k], ~flag_tab[k], 1'b0, 32'h500);
            step();
            total++;
            if (redirect !== 1'b0) $display("FAIL sel_not_taken f3=%b: got %b want 0", f3_tab[k], redirect);
            else passed++;
        end
        drive_idle();
        step();
    endtask

    task automatic test_illegal();
        drive_resolve(32'h8, 3'b010, 6'b111111, 1'b0, 32'h600);
        step();
        drive_idle();
        total++; if (illegal_br !== 1'b1) $display("FAIL ill_strobe: got %b want 1", illegal_br); else passed++;
        total++; if (redirect !== 1'b0) $display("FAIL ill_redirect: got %b want 0", redirect); else passed++;
        total++; if (branch_count !== 32'd17) $display("FAIL ill_branch_count: got %0d want 17", branch_count); else passed++;
        total++; if (mispredict_count !== 32'd10) $display("FAIL ill_mispredict_count: got %0d want 10", mispredict_count); else passed++;
        fetch_pc = 32'h8;
        #1;
        total++; if (pred_taken !== 1'b0) $display("FAIL ill_table: got %b want 0", pred_taken); else passed++;
        step();
        total++; if (illegal_br !== 1'b0) $display("FAIL ill_one_cycle: got %b want 0", illegal_br); else passed++;
    endtask

    task automatic test_async_reset();
        drive_resolve(32'h100, 3'b000, 6'b100000, 1'b0, 32'h200);
        step();
        drive_idle();
        total++; if (redirect !== 1'b1) $display("FAIL ar_pre_redirect: got %b want 1", redirect); else passed++;
        fetch_pc = 32'h100;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL ar_redirect: got %b want 0", redirect); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL ar_redirect_pc: got %h want 0", redirect_pc); else passed++;
        total++; if (branch_count !== 32'h0) $display("FAIL ar_branch_count: got %0d want 0", branch_count); else passed++;
        total++; if (mispredict_count !== 32'h0) $display("FAIL ar_mispredict_count: got %0d want 0", mispredict_count); else passed++;
        total++; if (pred_taken !== 1'b0) $display("FAIL ar_pred_0x100: got %b want 0", pred_taken); else passed++;
        fetch_pc = 32'hFFFF_FFFC;
        #1;
        total++; if (pred_taken !== 1'b0) $display("FAIL ar_pred_idx15: got %b want 0", pred_taken); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_first_mispredict();
        test_saturate();
        test_back_to_back();
        test_bltu_wrap();
        test_funct3_select();
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
